// File: rtl/scale_seg_pkg.sv
// Shared constants for the scale reading display: digit counts, segment codes,
// BCD engine state encodings and the digit-to-segment lookup.
package scale_seg_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int BCD_DIGITS = 4;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}, decimal point always off
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic [7:0] digit_to_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: 12-bit binary to four BCD digits,
// one bit per cycle, result and done strobe registered on leaving DONE.
module bin2bcd_seq
  import scale_seg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [11:0]             bin,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_DIGITS*4-1:0] bcd
);

  logic [1:0]              r_state;
  logic [11:0]             r_bin;
  logic [BCD_DIGITS*4-1:0] r_acc;
  logic [3:0]              r_bitCnt;
  logic                    r_done;
  logic [BCD_DIGITS*4-1:0] r_bcd;
  logic [BCD_DIGITS*4-1:0] w_accAdj;

  always_comb begin
    w_accAdj = r_acc;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_acc[i*4 +: 4] >= 4'd5) w_accAdj[i*4 +: 4] = r_acc[i*4 +: 4] + 4'd3;
    end
  end

  // Start is honoured only in IDLE; pulses during SHIFT/DONE are simply lost
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_bin    <= '0;
      r_acc    <= '0;
      r_bitCnt <= '0;
      r_done   <= 1'b0;
      r_bcd    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bin    <= bin;
            r_acc    <= '0;
            r_bitCnt <= '0;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {r_acc, r_bin} <= {w_accAdj, r_bin} << 1;
          r_bitCnt       <= r_bitCnt + 4'd1;
          if (r_bitCnt == 4'd11) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_bcd   <= r_acc;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: rtl/scale_seg_display.sv
// Scale reading to 6-digit multiplexed common-anode display: BCD conversion,
// leading-zero blanking, over-range dashes and digit scanning.
module scale_seg_display
  import scale_seg_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int SCAN_DIV  = CLK_FREQ / 1000,
  parameter int MAX_VALUE = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           din,
  input  logic                  din_val,
  output logic                  busy,
  output logic [NUM_DIGITS-1:0] seg_sel,
  output logic [7:0]            seg_data
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic                    w_busy;
  logic                    w_done;
  logic [BCD_DIGITS*4-1:0] w_bcd;
  logic                    r_overPend;
  logic [BCD_DIGITS*4-1:0] r_dispBcd;
  logic                    r_dispOver;
  logic [CNT_W-1:0]        r_scanCnt;
  logic [2:0]              r_scanIdx;
  logic [NUM_DIGITS-1:0]   r_segSel;
  logic [7:0]              r_segData;
  logic [7:0]              w_segNext;
  logic [3:0]              w_d0, w_d1, w_d2, w_d3;
  logic                    w_upper3Zero, w_upper2Zero, w_upper1Zero;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (din_val),
    .bin   (din),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  // Over flag is latched at the same moment the engine accepts the reading,
  // and both reach the display together so no digit mixes old and new data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overPend <= 1'b0;
      r_dispBcd  <= '0;
      r_dispOver <= 1'b0;
    end else begin
      if (din_val && !w_busy) r_overPend <= (int'(din) > MAX_VALUE);
      if (w_done) begin
        r_dispBcd  <= w_bcd;
        r_dispOver <= r_overPend;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scanCnt <= '0;
      r_scanIdx <= '0;
    end else if (r_scanCnt == CNT_W'(SCAN_DIV - 1)) begin
      r_scanCnt <= '0;
      r_scanIdx <= (r_scanIdx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_scanIdx + 3'd1;
    end else begin
      r_scanCnt <= r_scanCnt + CNT_W'(1);
    end
  end

  assign w_d0         = r_dispBcd[3:0];
  assign w_d1         = r_dispBcd[7:4];
  assign w_d2         = r_dispBcd[11:8];
  assign w_d3         = r_dispBcd[15:12];
  assign w_upper3Zero = (w_d3 == 4'd0);
  assign w_upper2Zero = w_upper3Zero && (w_d2 == 4'd0);
  assign w_upper1Zero = w_upper2Zero && (w_d1 == 4'd0);

  // Units digit is never blanked so a zero reading still shows "0"
  always_comb begin
    w_segNext = SEG_BLANK;
    if (r_dispOver) begin
      if (r_scanIdx < 3'(BCD_DIGITS)) w_segNext = SEG_DASH;
    end else begin
      case (r_scanIdx)
        3'd0:    w_segNext = digit_to_seg(w_d0);
        3'd1:    w_segNext = w_upper1Zero ? SEG_BLANK : digit_to_seg(w_d1);
        3'd2:    w_segNext = w_upper2Zero ? SEG_BLANK : digit_to_seg(w_d2);
        3'd3:    w_segNext = w_upper3Zero ? SEG_BLANK : digit_to_seg(w_d3);
        default: w_segNext = SEG_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_segSel  <= '1;
      r_segData <= SEG_BLANK;
    end else begin
      r_segSel  <= ~(NUM_DIGITS'(1) << r_scanIdx);
      r_segData <= w_segNext;
    end
  end

  assign busy     = w_busy;
  assign seg_sel  = r_segSel;
  assign seg_data = r_segData;

endmodule

// File: tb/tb_scale_seg_display.sv
// Scoreboard bench for scale_seg_display: readings are queued as they are driven
// and the scanned digits are compared against a decimal model once they appear.
module tb_scale_seg_display;

  logic        clk;
  logic        rst;
  logic [11:0] din;
  logic        din_val;
  logic        busy;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_data;

  int vectors     = 0;
  int miscompares = 0;
  int expQ[$];

  scale_seg_display #(.SCAN_DIV(4), .MAX_VALUE(500)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_val  (din_val),
    .busy     (busy),
    .seg_sel  (seg_sel),
    .seg_data (seg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] expSeg(input int value, input int k);
    logic [7:0] codes[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int p;
    if (k >= 4) return 8'hFF;
    if (value > 500) return 8'hBF;
    p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
    if (k > 0 && value < p) return 8'hFF;
    return codes[(value / p) % 10];
  endfunction

  // Called at a negedge; the pulse is sampled on the next posedge
  task automatic applyStimulus(input int value, input bit push);
    din     = 12'(value);
    din_val = 1'b1;
    if (push) expQ.push_back(value);
    @(posedge clk);
    #1;
    din_val = 1'b0;
  endtask

  task automatic measureBusy(output int len);
    bit ended = 0;
    len = 0;
    for (int i = 0; i < 40 && !ended; i++) begin
      @(negedge clk);
      if (busy) len++;
      else ended = 1;
    end
    if (!ended) checkOutput("busyTimeout", 32'd1, 32'd0);
  endtask

  task automatic popAndCheck(input int skip, input int window, input bit requireAll);
    int value, idx, prevIdx, runLen, bad;
    bit firstRun;
    logic [5:0] seen;
    if (expQ.size() == 0) begin
      checkOutput("queueEmpty", 32'd1, 32'd0);
      return;
    end
    value    = expQ.pop_front();
    prevIdx  = -1;
    runLen   = 0;
    bad      = 0;
    firstRun = 1;
    seen     = '0;
    repeat (skip) @(negedge clk);
    for (int i = 0; i < window; i++) begin
      idx = -1;
      for (int k = 0; k < 6; k++) if (seg_sel == ~(6'(1) << k)) idx = k;
      if (idx < 0) begin
        bad++;
      end else begin
        seen[idx] = 1'b1;
        checkOutput($sformatf("digit%0d(%0d)", idx, value), 32'(seg_data),
                    32'(expSeg(value, idx)));
        if (prevIdx >= 0 && idx != prevIdx) begin
          checkOutput("scanOrder", 32'(idx), 32'((prevIdx + 1) % 6));
          if (!firstRun) checkOutput("scanDwell", 32'(runLen), 32'd4);
          firstRun = 0;
          runLen   = 0;
        end
        runLen++;
        prevIdx = idx;
      end
      @(negedge clk);
    end
    checkOutput("segSelValid", 32'(bad), 32'd0);
    if (requireAll) checkOutput("allDigits", 32'(seen), 32'h3F);
    else            checkOutput("someDigits", 32'(seen != 6'd0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int len;
    int vals[5] = '{500, 7, 0, 4095, 123};

    rst = 1'b1; din = '0; din_val = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstSel", 32'(seg_sel), 32'h3F);
    checkOutput("rstData", 32'(seg_data), 32'hFF);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("firstSel", 32'(seg_sel), 32'h3E);
    checkOutput("firstData", 32'(seg_data), 32'hC0);
    repeat (4) @(negedge clk);
    checkOutput("secondSel", 32'(seg_sel), 32'h3D);
    checkOutput("secondData", 32'(seg_data), 32'hFF);

    foreach (vals[i]) begin
      applyStimulus(vals[i], 1'b1);
      measureBusy(len);
      checkOutput($sformatf("busyLen(%0d)", vals[i]), 32'(len), 32'd13);
      popAndCheck(2, 28, 1'b1);
    end

    // Pulse while busy is dropped; a pulse right after busy falls is taken
    applyStimulus(120, 1'b1);
    repeat (5) @(negedge clk);
    applyStimulus(77, 1'b0);
    measureBusy(len);
    checkOutput("busyRemain", 32'(len), 32'd8);
    applyStimulus(42, 1'b1);
    checkOutput("busyAccept", 32'(busy), 32'd1);
    popAndCheck(2, 13, 1'b0);
    popAndCheck(1, 28, 1'b1);

    // Pulse coincident with DONE->IDLE is dropped
    applyStimulus(55, 1'b1);
    repeat (13) @(negedge clk);
    checkOutput("busyInDone", 32'(busy), 32'd1);
    applyStimulus(66, 1'b0);
    checkOutput("dropCoincident", 32'(busy), 32'd0);
    popAndCheck(3, 28, 1'b1);
    checkOutput("noLateStart", 32'(busy), 32'd0);

    // Reset in the middle of a conversion
    applyStimulus(999, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("midRstSel", 32'(seg_sel), 32'h3F);
      checkOutput("midRstData", 32'(seg_data), 32'hFF);
      checkOutput("midRstBusy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    expQ.push_back(0);
    popAndCheck(1, 60, 1'b1);
    checkOutput("postRstBusy", 32'(busy), 32'd0);

    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
